garage_door_plant: RTL and testbench

Cycle-based behavioural-synthesizable model of the garage door mechanics: motor, position, end-stop sensors and light barrier. It consumes the motor commands `left`/`right` produced by the door controller and returns the `top`, `bottom` and `lb` sensor signals that controller expects. It is instantiated next to the controller in the FPGA demo top level and in the closed-loop testbench, so the controller can be exercised without real hardware.

---
 rtl/garage_door_pkg.sv | 27 ++
 rtl/garage_door_plant_step_prescaler.sv | 51 +++++
 rtl/garage_door_plant.sv | 168 ++++++++++++++++
 tb/tb_garage_door_plant.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/garage_door_pkg.sv
// Shared definitions for the garage door plant model and for the benches
// that drive the door controller against it.
//
// Contents:
//   plant_state_t        : plant motor state (IDLE, OPENING, CLOSING, FAULT)
//   ST_*                 : the same encodings as plain 2-bit constants, for
//                          code that keeps its state in a logic vector
//   GD_STEP_DIV          : default clock cycles per position step (1 ms @ 50 MHz)
//   GD_POS_MAX           : default position of the fully open door
package garage_door_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OPENING = 2'd1,
    CLOSING = 2'd2,
    FAULT   = 2'd3
  } plant_state_t;

  localparam logic [1:0] ST_IDLE    = 2'(IDLE);
  localparam logic [1:0] ST_OPENING = 2'(OPENING);
  localparam logic [1:0] ST_CLOSING = 2'(CLOSING);
  localparam logic [1:0] ST_FAULT   = 2'(FAULT);

  localparam int GD_STEP_DIV = 50_000;
  localparam int GD_POS_MAX  = 1000;

endpackage

// File: rtl/garage_door_plant_step_prescaler.sv
// step_prescaler: divides the system clock down to door position steps.
//
// Ports:
//   clk50m : system clock, rising edge
//   rst    : synchronous active-high reset
//   en     : count while high (motor running); held at 0 while low
//   clr    : restart the count from 0 (state change of the plant)
//   tick   : registered one-cycle pulse, raised on the edge where the count
//            reaches DIV-1, so the position moves one edge later
module step_prescaler
  import garage_door_pkg::*;
#(
  parameter int DIV = GD_STEP_DIV
) (
  input  logic clk50m,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // Counter wraps at DIV-1; a clear also drops any pending tick so a
  // reversal never inherits progress from the previous direction.
  always_comb begin
    cnt_d  = '0;
    tick_d = 1'b0;
    if (en && !clr) begin
      tick_d = (cnt_q == LAST);
      cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk50m) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/garage_door_plant.sv
// garage_door_plant: cycle-based model of the garage door mechanics (motor,
// position, end-stop sensors, light barrier) for closed-loop use with the
// door controller.
//
// Ports:
//   clk50m   : system clock, rising edge
//   rst      : synchronous active-high reset; returns the door to RESET_POS
//   left     : motor command open  (position increments)
//   right    : motor command close (position decrements)
//   obstacle : asynchronous object-in-doorway stimulus
//   top      : high iff pos == POS_MAX
//   bottom   : high iff pos == 0
//   lb       : light barrier interrupted (never while the door is closed)
//   pos      : current door position, 0 = closed
//   moving   : motor running and not pressed against the end stop
//   fault    : sticky plant fault, cleared only by rst
//
// Build option GD_PLANT_STALL_EN: when defined, STALL_STEPS step ticks spent
// against the end stop in the travel direction raise a stall fault. When not
// defined, driving into an end stop simply holds the position saturated.
module garage_door_plant
  import garage_door_pkg::*;
#(
  parameter int STEP_DIV    = GD_STEP_DIV,
  parameter int POS_MAX     = GD_POS_MAX,
  parameter int RESET_POS   = 500,
  parameter int STALL_STEPS = 200,
  parameter int POS_W       = $clog2(POS_MAX + 1)
) (
  input  logic             clk50m,
  input  logic             rst,
  input  logic             left,
  input  logic             right,
  input  logic             obstacle,
  output logic             top,
  output logic             bottom,
  output logic             lb,
  output logic [POS_W-1:0] pos,
  output logic             moving,
  output logic             fault
);

  localparam logic [POS_W-1:0] POS_TOP   = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0] POS_RESET = POS_W'(RESET_POS);

  logic [1:0]       state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             top_q, bottom_q, lb_q, moving_q, fault_q;
  logic             sync1_q, sync2_q;
  logic             step_tick;
  logic             state_change;
  logic             at_stop;
  logic             stall_hit;

  // Motor is pressed against the end stop it is driving towards.
  assign at_stop = ((state_q == ST_OPENING) && (pos_q == POS_TOP)) ||
                   ((state_q == ST_CLOSING) && (pos_q == '0));

`ifdef GD_PLANT_STALL_EN
  localparam int STALL_W = $clog2(STALL_STEPS + 1);
  localparam logic [STALL_W-1:0] STALL_LIM = STALL_W'(STALL_STEPS);

  logic [STALL_W-1:0] stall_q, stall_d;

  // Counts ticks wasted against the end stop; any state change starts over.
  always_comb begin
    stall_hit = step_tick && at_stop && ((stall_q + STALL_W'(1)) == STALL_LIM);
    stall_d   = stall_q;
    if (state_change) begin
      stall_d = '0;
    end else if (step_tick && at_stop && (stall_q != STALL_LIM)) begin
      stall_d = stall_q + STALL_W'(1);
    end
  end

  always_ff @(posedge clk50m) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end
`else
  logic unused_stall_cfg;
  assign unused_stall_cfg = (STALL_STEPS != 0);
  assign stall_hit        = 1'b0;
`endif

  // Command decode; FAULT is absorbing until reset. Both commands at once
  // model a shorted motor.
  always_comb begin
    state_d = state_q;
    if (state_q != ST_FAULT) begin
      if (left && right) begin
        state_d = ST_FAULT;
      end else if (left) begin
        state_d = ST_OPENING;
      end else if (right) begin
        state_d = ST_CLOSING;
      end else begin
        state_d = ST_IDLE;
      end
      if (stall_hit) begin
        state_d = ST_FAULT;
      end
    end
  end

  assign state_change = (state_d != state_q);

  step_prescaler #(
    .DIV(STEP_DIV)
  ) u_prescaler (
    .clk50m(clk50m),
    .rst   (rst),
    .en    ((state_q == ST_OPENING) || (state_q == ST_CLOSING)),
    .clr   (state_change),
    .tick  (step_tick)
  );

  // A tick moves the door one step in the direction it was earned in,
  // saturating at either end.
  always_comb begin
    pos_d = pos_q;
    if (step_tick) begin
      if ((state_q == ST_OPENING) && (pos_q != POS_TOP)) begin
        pos_d = pos_q + POS_W'(1);
      end else if ((state_q == ST_CLOSING) && (pos_q != '0)) begin
        pos_d = pos_q - POS_W'(1);
      end
    end
  end

  // Outputs are decoded from next-state values so they change on the same
  // edge as state and position.
  always_ff @(posedge clk50m) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      pos_q    <= POS_RESET;
      top_q    <= (RESET_POS == POS_MAX);
      bottom_q <= (RESET_POS == 0);
      lb_q     <= 1'b0;
      moving_q <= 1'b0;
      fault_q  <= 1'b0;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      top_q    <= (pos_d == POS_TOP);
      bottom_q <= (pos_d == '0);
      sync1_q  <= obstacle;
      sync2_q  <= sync1_q;
      lb_q     <= sync2_q && (pos_d != '0);
      moving_q <= ((state_d == ST_OPENING) && (pos_d != POS_TOP)) ||
                  ((state_d == ST_CLOSING) && (pos_d != '0));
      fault_q  <= (state_d == ST_FAULT);
    end
  end

  assign top    = top_q;
  assign bottom = bottom_q;
  assign lb     = lb_q;
  assign pos    = pos_q;
  assign moving = moving_q;
  assign fault  = fault_q;

endmodule

// File: tb/tb_garage_door_plant.sv
// Directed bench for garage_door_plant with STEP_DIV=4, POS_MAX=10,
// RESET_POS=5, STALL_STEPS=3. Honours GD_PLANT_STALL_EN when defined.
module tb_garage_door_plant;

  localparam int STEP_DIV    = 4;
  localparam int POS_MAX     = 10;
  localparam int RESET_POS   = 5;
  localparam int STALL_STEPS = 3;
  localparam int POS_W       = 4;
`ifdef GD_PLANT_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic             clk50m = 1'b0;
  logic             rst;
  logic             left;
  logic             right;
  logic             obstacle;
  logic             top;
  logic             bottom;
  logic             lb;
  logic [POS_W-1:0] pos;
  logic             moving;
  logic             fault;

  int compared   = 0;
  int mismatched = 0;

  garage_door_plant #(
    .STEP_DIV   (STEP_DIV),
    .POS_MAX    (POS_MAX),
    .RESET_POS  (RESET_POS),
    .STALL_STEPS(STALL_STEPS),
    .POS_W      (POS_W)
  ) dut (
    .clk50m  (clk50m),
    .rst     (rst),
    .left    (left),
    .right   (right),
    .obstacle(obstacle),
    .top     (top),
    .bottom  (bottom),
    .lb      (lb),
    .pos     (pos),
    .moving  (moving),
    .fault   (fault)
  );

  // 10-unit period free-running clock.
  always #5 clk50m = ~clk50m;

  task automatic applyStimulus(input logic l, input logic r, input logic o, input logic rs);
    left     = l;
    right    = r;
    obstacle = o;
    rst      = rs;
  endtask

  // Advance n rising edges and settle 1 unit past the last one.
  task automatic stepEdges(input int n);
    repeat (n) @(posedge clk50m);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    stepEdges(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int expPos;
    int expFault;
    int expLb;

    // Reset, then idle for 20 edges.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    stepEdges(2);
    checkOutput("reset_pos", 32'(pos), 32'(5));
    checkOutput("reset_flags", 32'({top, bottom, lb, moving, fault}), 32'(0));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      stepEdges(1);
      checkOutput($sformatf("idle_pos@%0d", k), 32'(pos), 32'(5));
      checkOutput($sformatf("idle_flags@%0d", k), 32'({top, bottom, lb, moving, fault}), 32'(0));
    end

    // Open all the way and keep pushing against the top stop.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k <= 40; k++) begin
      stepEdges(1);
      expPos = (k < 5) ? 5 : 6 + (k - 5) / 4;
      if (expPos > 10) expPos = 10;
      expFault = (STALL_EN && k >= 33) ? 1 : 0;
      checkOutput($sformatf("open_pos@%0d", k), 32'(pos), 32'(expPos));
      checkOutput($sformatf("open_top@%0d", k), 32'(top), 32'(expPos == 10));
      checkOutput($sformatf("open_moving@%0d", k), 32'(moving), 32'(expPos != 10));
      checkOutput($sformatf("open_fault@%0d", k), 32'(fault), 32'(expFault));
    end

    doReset();
    checkOutput("rst_after_open_pos", 32'(pos), 32'(5));
    checkOutput("rst_after_open_flags", 32'({top, bottom, lb, moving, fault}), 32'(0));

    // Close all the way with an obstacle appearing at pos 3 and held.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k <= 26; k++) begin
      stepEdges(1);
      expPos = (k < 5) ? 5 : 4 - (k - 5) / 4;
      if (expPos < 0) expPos = 0;
      expLb = (k >= 12 && k <= 20) ? 1 : 0;
      checkOutput($sformatf("close_pos@%0d", k), 32'(pos), 32'(expPos));
      checkOutput($sformatf("close_bottom@%0d", k), 32'(bottom), 32'(expPos == 0));
      checkOutput($sformatf("close_moving@%0d", k), 32'(moving), 32'(expPos != 0));
      checkOutput($sformatf("close_lb@%0d", k), 32'(lb), 32'(expLb));
      if (k == 9) obstacle = 1'b1;
    end

    doReset();
    checkOutput("rst_after_close_lb", 32'(lb), 32'(0));

    // Open for 10 edges, then reverse without a gap.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k <= 24; k++) begin
      stepEdges(1);
      if (k < 5) expPos = 5;
      else if (k < 9) expPos = 6;
      else if (k < 15) expPos = 7;
      else expPos = 6 - (k - 15) / 4;
      checkOutput($sformatf("rev_pos@%0d", k), 32'(pos), 32'(expPos));
      checkOutput($sformatf("rev_moving@%0d", k), 32'(moving), 32'(1));
      if (k == 9) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    end

    doReset();

    // Motor short mid-travel, then commands released and re-applied.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k <= 17; k++) begin
      stepEdges(1);
      expPos = (k < 5) ? 5 : 6;
      checkOutput($sformatf("short_pos@%0d", k), 32'(pos), 32'(expPos));
      checkOutput($sformatf("short_fault@%0d", k), 32'(fault), 32'(k >= 7));
      checkOutput($sformatf("short_moving@%0d", k), 32'(moving), 32'(k < 7));
      if (k == 6) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      if (k == 7) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      if (k == 8) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      if (k == 12) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    end

    doReset();
    checkOutput("rst_after_short_pos", 32'(pos), 32'(5));
    checkOutput("rst_after_short_flags", 32'({top, bottom, lb, moving, fault}), 32'(0));

    // Reset while travelling returns the door to its start position.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    stepEdges(10);
    checkOutput("midtravel_pos", 32'(pos), 32'(7));
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    stepEdges(1);
    checkOutput("midtravel_rst_pos", 32'(pos), 32'(5));
    checkOutput("midtravel_rst_moving", 32'(moving), 32'(0));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    stepEdges(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
